sonar_filter: RTL and testbench
===============================

# sonar_filter

Downstream conditioning stage for the SR04 sonar front end. Consumes raw 8-bit echo-time samples and their one-cycle valid strobe, and produces three outputs for the register interface: a moving-average distance, a hysteretic "object near" flag, and a stale flag that asserts when the sonar stops returning echoes.

## Interface
- `WIN_LOG2`, default 2: window depth is 2^WIN_LOG2 samples; legal values 1..4.
- `STALE_CYCLES`, default 2500000: cycles without an accepted sample before `stale` asserts (50 ms at 50 MHz); must be ≥ 2.
- `clk` in 1: system clock, 50 MHz.
- `reset_n` in 1: reset, asynchronous and active-low.
- `en` in 1: filter enable; low flushes the window.
- `din` in 8: raw distance sample, 0.55 in/LSB.
- `din_valid` in 1: one-cycle strobe, `din` is valid.
- `near_thresh` in 8: near-set threshold, static.
- `hyst` in 8: hysteresis added to the threshold for clearing, static.
- `avg_dist` out 8: filtered distance.
- `avg_valid` out 1: one-cycle pulse, `avg_dist` updated.
- `near` out 1: object-near flag.
- `stale` out 1: no sample within `STALE_CYCLES`.

## Operation
- **Storage:** ring buffer of 2^WIN_LOG2 × 8 bits, a write pointer, an `empty` flag and a running `sum` of (8+WIN_LOG2) bits.
- **Accept:** a sample is accepted when `en && din_valid`.
- **Priming:** if `empty`, an accepted sample writes `din` to every entry and sets `sum = din << WIN_LOG2`, then clears `empty`.
- **Normal update:** otherwise the sample overwrites the entry at the pointer and sets `sum = sum - old_entry + din`. The pointer increments modulo window depth. `sum` never over- or underflows.
- **Average:** `avg_dist = sum >> WIN_LOG2` (truncating).
- **Near set:** on each new average, `near` sets if avg < `near_thresh`.
- **Near clear:** `near` clears if avg ≥ `near_thresh + hyst`, computed as a 9-bit sum. If that sum exceeds 255, `near` can only clear via stale or `en`.
- **Near hold:** between the set and clear levels, `near` holds.
- **Stale counter:** counts cycles with `en` high and no accepted sample.
  - An accepted sample zeroes the counter.
  - When the count reaches `STALE_CYCLES-1` with no sample that cycle, the following happens at that edge: `stale`←1, `near`←0, `empty`←1. The counter holds.
- **Stale exit:** the next accepted sample clears `stale` and re-primes the window.
- **`en` low**, every cycle:
  - `empty`←1, pointer←0, counter←0.
  - `stale`←0, `near`←0, `avg_valid`←0.
  - `avg_dist` holds.
- **Reset values:** `avg_dist`=0, `avg_valid`=0, `near`=0, `stale`=0, `empty`=1, pointer=0, `sum`=0, counter=0.

## Timing
- **Sample edge:** sample accepted at edge k; buffer, `sum`, `empty` and pointer update at edge k.
- **Output edge:** `avg_dist`, `near` and `avg_valid`=1 update at edge k+1. `near` is computed from the value being loaded into `avg_dist`.
- **Pulse width:** `avg_valid` is high exactly one cycle.
- **Back-to-back samples:** `din_valid` on consecutive cycles is supported. Each sample gives its own `avg_valid` pulse, one cycle later, in order.
- **Sample vs. timeout:** if an accepted sample coincides with the stale terminal count, the sample wins. `stale` stays 0 and the counter resets.
- **Stale vs. pending output:** if `stale` asserts the same edge a pending average is output, `near`←0 takes priority over the comparison.
- **`din_valid` while `en` low:** ignored; no `avg_valid` results.
- **Reset:** asynchronous assertion forces all reset values immediately, mid-window or mid-pulse. Release is synchronised externally; the first accepted sample after release primes.

## Structure
- **Shared package `sonar_pkg`:** `DIST_W`=8 and `CLK_HZ`=50000000 belong here; `STALE_CYCLES` defaults are derived from `CLK_HZ`.
- **Sub-module `sonar_hyst`:** the hysteresis comparator. Inputs are the value, its strobe, `near_thresh`, `hyst` and a force-clear; output is `near`.
- **Top level:** ring buffer, accumulator and stale counter stay in `sonar_filter`.

## Test plan
All scenarios use WIN_LOG2=2; scenarios 1-4 and 6 also use STALE_CYCLES=100.

1. **Priming:** reset, `en`=1, single sample 40 → `avg_valid` pulses one cycle after the strobe; `avg_dist`=40, `stale`=0.
2. **Window fill:** after priming with 40, samples 80,80,80,80 → `avg_dist` sequence 50,60,70,80, each with one `avg_valid` pulse. Back-to-back strobes give the same sequence.
3. **Hysteresis:** `near_thresh`=30, `hyst`=10, primed averages 29 → 35 → 39 → 40 → `near` 1,1,1,0. With `near_thresh`=250, `hyst`=10, averages 249 then 255 → `near` stays 1.
4. **Stale:** after sample 20 with `near`=1, no strobe for 100 cycles → `stale`=1 and `near`=0 at cycle 100. Next sample 90 → `avg_dist`=90 (re-primed), `stale`=0. A strobe on the terminal cycle → `stale` never asserts.
5. **`en` drop:** window holding 10,10,50,50; drop `en` one cycle; then sample 70 → `avg_dist`=70, not a mixed average. Strobe during `en`=0 → no `avg_valid`.
6. **Async reset mid-operation:** assert `reset_n` low between a strobe and its `avg_valid` → outputs zero immediately, no pulse. After release, sample 33 → `avg_dist`=33.

Source files
------------

// File: rtl/sonar_pkg.sv
// sonar_pkg: shared widths and clock-derived defaults for the sonar conditioning path
package sonar_pkg;
  localparam int DIST_W = 8;
  localparam int CLK_HZ = 50_000_000;
  localparam int STALE_DEFAULT = CLK_HZ / 20;
endpackage

// File: rtl/sonar_hyst.sv
// sonar_hyst: hysteretic near flag, set below threshold, cleared at threshold plus hysteresis
module sonar_hyst
  import sonar_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DIST_W-1:0] val,
  input  logic              stb,
  input  logic [DIST_W-1:0] near_thresh,
  input  logic [DIST_W-1:0] hyst,
  input  logic              clr,
  output logic              near
);
  // 9-bit clear level: above 255 the compare can never clear the flag
  logic [DIST_W:0] clr_lvl;
  assign clr_lvl = {1'b0, near_thresh} + {1'b0, hyst};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) near <= 1'b0;
    else if (clr) near <= 1'b0;
    else if (stb && val < near_thresh) near <= 1'b1;
    else if (stb && {1'b0, val} >= clr_lvl) near <= 1'b0;
endmodule

// File: rtl/sonar_filter.sv
// sonar_filter: moving-average echo filter with hysteretic near flag and stale-echo timeout
module sonar_filter
  import sonar_pkg::*;
#(
  parameter int WIN_LOG2     = 2,
  parameter int STALE_CYCLES = STALE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [DIST_W-1:0] din,
  input  logic              din_valid,
  input  logic [DIST_W-1:0] near_thresh,
  input  logic [DIST_W-1:0] hyst,
  output logic [DIST_W-1:0] avg_dist,
  output logic              avg_valid,
  output logic              near,
  output logic              stale
);
  localparam int N  = 1 << WIN_LOG2;
  localparam int SW = DIST_W + WIN_LOG2;
  localparam int CW = $clog2(STALE_CYCLES);
  logic [DIST_W-1:0] ring [N];
  logic [WIN_LOG2-1:0] ptr;
  logic [SW-1:0] sum;
  logic [CW-1:0] cnt;
  logic empty, pend, acc, timeout;
  logic [DIST_W-1:0] avg_next;
  assign acc      = en && din_valid;
  assign timeout  = en && !acc && cnt == CW'(STALE_CYCLES - 1);
  assign avg_next = DIST_W'(sum >> WIN_LOG2);
  // buffer contents are don't-care until primed, so they carry no reset
  always_ff @(posedge clk)
    if (acc && empty) for (int i = 0; i < N; i++) ring[i] <= din;
    else if (acc) ring[ptr] <= din;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      avg_dist  <= '0;
      avg_valid <= 1'b0;
      stale     <= 1'b0;
      empty     <= 1'b1;
      pend      <= 1'b0;
      ptr       <= '0;
      sum       <= '0;
      cnt       <= '0;
    end else if (!en) begin
      avg_valid <= 1'b0;
      stale     <= 1'b0;
      empty     <= 1'b1;
      pend      <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      pend      <= acc;
      avg_valid <= pend;
      if (pend) avg_dist <= avg_next;
      if (acc) begin
        cnt   <= '0;
        stale <= 1'b0;
        empty <= 1'b0;
        if (empty) sum <= SW'(din) << WIN_LOG2;
        else begin
          sum <= sum - SW'(ring[ptr]) + SW'(din);
          ptr <= ptr + 1'b1;
        end
      end else if (timeout) begin
        stale <= 1'b1;
        empty <= 1'b1;
      end else cnt <= cnt + 1'b1;
    end
  // the timeout clear outranks a comparison landing on the same edge
  sonar_hyst u_hyst (
    .clk(clk),
    .reset_n(reset_n),
    .val(avg_next),
    .stb(en && pend),
    .near_thresh(near_thresh),
    .hyst(hyst),
    .clr(!en || timeout),
    .near(near)
  );
endmodule

// File: tb/tb_sonar_filter.sv
// tb_sonar_filter: directed checks of priming, averaging, hysteresis, stale, enable and reset
module tb_sonar_filter;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic en = 1'b0;
  logic [7:0] din = '0;
  logic din_valid = 1'b0;
  logic [7:0] near_thresh = '0;
  logic [7:0] hyst = '0;
  logic [7:0] avg_dist;
  logic avg_valid, near, stale;
  int checks = 0;
  int errors = 0;
  logic [7:0] bexp [4] = '{8'd50, 8'd60, 8'd70, 8'd80};

  always #5 clk = ~clk;

  sonar_filter #(.WIN_LOG2(2), .STALE_CYCLES(100)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .en(en),
    .din(din),
    .din_valid(din_valid),
    .near_thresh(near_thresh),
    .hyst(hyst),
    .avg_dist(avg_dist),
    .avg_valid(avg_valid),
    .near(near),
    .stale(stale)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] exp, input string tag);
    @(negedge clk);
    din = d;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 16'(avg_valid), 16'd1);
    chk(tag, 16'(avg_dist), 16'(exp));
  endtask

  task automatic flush();
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1;
    chk("rst_avg", 16'(avg_dist), 16'd0);
    chk("rst_valid", 16'(avg_valid), 16'd0);
    chk("rst_near", 16'(near), 16'd0);
    chk("rst_stale", 16'(stale), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    en = 1'b1;
    // priming
    send(8'd40, 8'd40, "prime");
    chk("prime_stale", 16'(stale), 16'd0);
    @(posedge clk);
    #1;
    chk("pulse_width", 16'(avg_valid), 16'd0);
    // window fill, spaced strobes
    send(8'd80, 8'd50, "fill0");
    send(8'd80, 8'd60, "fill1");
    send(8'd80, 8'd70, "fill2");
    send(8'd80, 8'd80, "fill3");
    // window fill, back-to-back strobes
    flush();
    send(8'd40, 8'd40, "reprime");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      din = 8'd80;
      din_valid = (i < 4);
      if (i >= 2) begin
        chk("b2b_valid", 16'(avg_valid), 16'd1);
        chk("b2b", 16'(avg_dist), 16'(bexp[i-2]));
      end
    end
    @(negedge clk);
    chk("b2b_end", 16'(avg_valid), 16'd0);
    // hysteresis 30/40
    near_thresh = 8'd30;
    hyst = 8'd10;
    flush();
    send(8'd29, 8'd29, "h29");
    chk("near_29", 16'(near), 16'd1);
    send(8'd35, 8'd30, "h35a");
    chk("near_30", 16'(near), 16'd1);
    send(8'd35, 8'd32, "h35b");
    send(8'd35, 8'd33, "h35c");
    send(8'd35, 8'd35, "h35d");
    chk("near_35", 16'(near), 16'd1);
    send(8'd39, 8'd36, "h39a");
    send(8'd39, 8'd37, "h39b");
    send(8'd39, 8'd38, "h39c");
    send(8'd39, 8'd39, "h39d");
    chk("near_39", 16'(near), 16'd1);
    send(8'd40, 8'd39, "h40a");
    send(8'd40, 8'd39, "h40b");
    send(8'd40, 8'd39, "h40c");
    chk("near_39b", 16'(near), 16'd1);
    send(8'd40, 8'd40, "h40d");
    chk("near_40", 16'(near), 16'd0);
    // clear level beyond 255
    near_thresh = 8'd250;
    flush();
    send(8'd249, 8'd249, "h249");
    chk("near_249", 16'(near), 16'd1);
    send(8'd255, 8'd250, "h255a");
    send(8'd255, 8'd252, "h255b");
    send(8'd255, 8'd253, "h255c");
    send(8'd255, 8'd255, "h255d");
    chk("near_255", 16'(near), 16'd1);
    // stale timeout
    near_thresh = 8'd30;
    flush();
    send(8'd20, 8'd20, "s20");
    chk("s_near", 16'(near), 16'd1);
    repeat (98) @(posedge clk);
    #1;
    chk("stale_99", 16'(stale), 16'd0);
    @(posedge clk);
    #1;
    chk("stale_100", 16'(stale), 16'd1);
    chk("stale_near", 16'(near), 16'd0);
    send(8'd90, 8'd90, "s90");
    chk("stale_exit", 16'(stale), 16'd0);
    repeat (98) @(negedge clk);
    send(8'd90, 8'd90, "s_term");
    chk("term_stale", 16'(stale), 16'd0);
    // en drop
    flush();
    send(8'd10, 8'd10, "e10");
    send(8'd50, 8'd20, "e50a");
    send(8'd50, 8'd30, "e50b");
    flush();
    send(8'd70, 8'd70, "e70");
    @(negedge clk);
    en = 1'b0;
    din = 8'd99;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("en0_valid", 16'(avg_valid), 16'd0);
    @(posedge clk);
    #1;
    chk("en0_valid2", 16'(avg_valid), 16'd0);
    chk("en0_hold", 16'(avg_dist), 16'd70);
    @(negedge clk);
    en = 1'b1;
    // async reset between strobe and output
    @(negedge clk);
    din = 8'd50;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_avg", 16'(avg_dist), 16'd0);
    chk("arst_valid", 16'(avg_valid), 16'd0);
    @(posedge clk);
    #1;
    chk("arst_nopulse", 16'(avg_valid), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_rel_valid", 16'(avg_valid), 16'd0);
    send(8'd33, 8'd33, "arst33");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
